sequence_generator: RTL and testbench

Produces the random digit sequence for one game. It sits directly upstream of the game controller: on a `GoGen` pulse it fills the 32-entry sequence RAM with digits whose range depends on the chosen difficulty, then pulses `FinGen`. The controller later reads the RAM through its own address port. A free-running LFSR supplies the randomness, so the sequence depends on when the player pressed start.

---
 rtl/sequence_generator.sv | 142 ++++++++++++++
 tb/tb_sequence_generator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// sequence_generator
//
// Fills the 32-entry game sequence RAM with random digits after a start
// request. The digit range depends on the latched difficulty. A free-running
// 16-bit LFSR supplies the randomness, so the sequence depends on the cycle
// in which the player pressed start.
//
// Ports:
//   Clk       - clock, all logic on the rising edge
//   Rst       - synchronous active-high reset
//   GoGen     - start request, sampled only while idle
//   Diff      - difficulty: 01 easy (1..4), 10 medium (1..7), 11 hard (1..9), 00 as 01
//   FinGen    - one-cycle pulse once all SEQ_LEN digits are written
//   Busy      - high from the cycle after a start is accepted through the FinGen cycle
//   RAMWrEn   - write strobe to the sequence RAM, one cycle per digit
//   RAMWrAddr - write address (held between writes)
//   RAMWrData - digit to write (held between writes)

module sequence_generator #(
  parameter int unsigned SEQ_LEN = 32,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       GoGen,
  input  logic [1:0] Diff,
  output logic       FinGen,
  output logic       Busy,
  output logic       RAMWrEn,
  output logic [4:0] RAMWrAddr,
  output logic [3:0] RAMWrData
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [4:0]  LastAddr = 5'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGen   = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } stateT;

  stateT       state;
  logic [15:0] lfsr;
  logic [1:0]  DiffQ;
  logic [4:0]  AddrCnt;

  logic [3:0]  cand;
  logic        accept;
  logic [3:0]  digit;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Runs in every state so the
  // sequence depends on the start time.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      lfsr <= SeedEff;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign cand = lfsr[3:0];

  // Map the current candidate to a digit for the latched difficulty.
  always_comb begin
    accept = 1'b0;
    digit  = 4'd0;
    case (DiffQ)
      2'b10: begin
        accept = (cand[2:0] != 3'd7);
        digit  = {1'b0, cand[2:0]} + 4'd1;
      end
      2'b11: begin
        accept = (cand >= 4'd1) && (cand <= 4'd9);
        digit  = cand;
      end
      default: begin
        accept = 1'b1;
        digit  = {2'b00, cand[1:0]} + 4'd1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= StIdle;
      DiffQ     <= 2'b01;
      AddrCnt   <= 5'd0;
      FinGen    <= 1'b0;
      Busy      <= 1'b0;
      RAMWrEn   <= 1'b0;
      RAMWrAddr <= 5'd0;
      RAMWrData <= 4'd0;
    end else begin
      // Strobes are single-cycle unless a state below raises them again.
      RAMWrEn <= 1'b0;
      FinGen  <= 1'b0;
      case (state)
        StIdle: begin
          Busy <= 1'b0;
          if (GoGen) begin
            DiffQ   <= (Diff == 2'b00) ? 2'b01 : Diff;
            AddrCnt <= 5'd0;
            Busy    <= 1'b1;
            state   <= StGen;
          end
        end
        StGen: begin
          // A rejected candidate simply waits for the next LFSR value.
          if (accept) begin
            RAMWrData <= digit;
            RAMWrAddr <= AddrCnt;
            RAMWrEn   <= 1'b1;
            state     <= StWrite;
          end
        end
        StWrite: begin
          if (AddrCnt == LastAddr) begin
            FinGen <= 1'b1;
            state  <= StDone;
          end else begin
            AddrCnt <= AddrCnt + 5'd1;
            state   <= StGen;
          end
        end
        StDone: begin
          Busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          Busy      <= 1'b0;
          RAMWrAddr <= 5'd0;
          RAMWrData <= 4'd0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: reset values, idle quiet period,
// exact digit streams for each difficulty against an LFSR reference, Diff
// latching, start-while-busy, and mid-run reset.

module tb_sequence_generator;

  localparam int unsigned SeqLen = 32;
  localparam logic [15:0] Seed   = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       GoGen;
  logic [1:0] Diff;
  logic       FinGen;
  logic       Busy;
  logic       RAMWrEn;
  logic [4:0] RAMWrAddr;
  logic [3:0] RAMWrData;

  sequence_generator #(
    .SEQ_LEN(SeqLen),
    .SEED   (Seed)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .GoGen    (GoGen),
    .Diff     (Diff),
    .FinGen   (FinGen),
    .Busy     (Busy),
    .RAMWrEn  (RAMWrEn),
    .RAMWrAddr(RAMWrAddr),
    .RAMWrData(RAMWrData)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mdl;
  logic [4:0]  wrAddr[$];
  logic [3:0]  wrData[$];
  int          finCnt;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // One clock: wait past the edge, advance the LFSR reference with the Rst
  // value the DUT saw at that edge, and log any write or FinGen.
  task automatic tick();
    @(posedge Clk);
    #1;
    mdl = Rst ? Seed : lfsrNext(mdl);
    if (RAMWrEn) begin
      wrAddr.push_back(RAMWrAddr);
      wrData.push_back(RAMWrData);
    end
    if (FinGen) finCnt++;
  endtask

  // Starts a run with difficulty d. goAt/diffAt/rstAt (>=0) inject a GoGen
  // pulse, a change of Diff to 11, or a reset once that many writes are seen.
  task automatic runGen(input logic [1:0] d, input int goAt, input int diffAt, input int rstAt);
    logic [15:0] v;
    logic [3:0]  r;
    logic [1:0]  de;
    logic [3:0]  exp[$];
    int          finAt;
    int          hi;
    int          bad;
    wrAddr.delete();
    wrData.delete();
    finCnt = 0;
    finAt  = -1;

    GoGen = 1'b1;
    Diff  = d;
    tick();
    v     = mdl;  // candidate of the first GEN cycle
    GoGen = 1'b0;
    checkVal("busy_after_go", Busy, 1);

    for (int c = 1; c <= 40 * SeqLen; c++) begin
      GoGen = 1'b0;
      if (goAt >= 0 && wrAddr.size() == goAt) begin
        GoGen = 1'b1;
        goAt  = -1;
      end
      if (diffAt >= 0 && wrAddr.size() == diffAt) begin
        Diff   = 2'b11;
        diffAt = -1;
      end
      if (rstAt >= 0 && wrAddr.size() == rstAt) begin
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        checkVal("rst_wren", RAMWrEn, 0);
        checkVal("rst_busy", Busy, 0);
        checkVal("rst_fin", FinGen, 0);
        for (int k = 0; k < 80; k++) tick();
        checkVal("rst_no_more_writes", wrAddr.size(), rstAt);
        checkVal("rst_no_fin", finCnt, 0);
        checkVal("rst_idle_busy", Busy, 0);
        return;
      end
      tick();
      if (FinGen) begin
        finAt = c;
        break;
      end
    end
    GoGen = 1'b0;

    checkVal("fin_seen", finAt > 0, 1);
    // GoGen edge is N; FinGen visible after edge N+64, i.e. the 65th cycle.
    if (d == 2'b01 || d == 2'b00) checkVal("fin_latency", finAt, 64);
    tick();
    checkVal("fin_single_cycle", FinGen, 0);
    checkVal("busy_low_after_fin", Busy, 0);
    checkVal("fin_count", finCnt, 1);
    checkVal("wr_count", wrAddr.size(), SeqLen);

    // Expected stream: an accept costs GEN+WRITE (two LFSR steps), a reject one.
    de = (d == 2'b00) ? 2'b01 : d;
    while (exp.size() < SeqLen) begin
      r = v[3:0];
      case (de)
        2'b10: begin
          if (r[2:0] != 3'd7) begin
            exp.push_back({1'b0, r[2:0]} + 4'd1);
            v = lfsrNext(v);
          end
        end
        2'b11: begin
          if (r >= 4'd1 && r <= 4'd9) begin
            exp.push_back(r);
            v = lfsrNext(v);
          end
        end
        default: begin
          exp.push_back({2'b00, r[1:0]} + 4'd1);
          v = lfsrNext(v);
        end
      endcase
      v = lfsrNext(v);
    end

    hi  = (de == 2'b11) ? 9 : (de == 2'b10) ? 7 : 4;
    bad = 0;
    for (int i = 0; i < wrAddr.size() && i < SeqLen; i++) begin
      checkVal($sformatf("addr[%0d]", i), wrAddr[i], i);
      checkVal($sformatf("digit[%0d]", i), wrData[i], exp[i]);
      if (wrData[i] < 1 || wrData[i] > hi) bad++;
    end
    checkVal("digit_range", bad, 0);
  endtask

  initial begin
    Rst   = 1'b1;
    GoGen = 1'b0;
    Diff  = 2'b01;
    finCnt = 0;
    mdl   = Seed;
    tick();
    tick();
    checkVal("reset_fin", FinGen, 0);
    checkVal("reset_busy", Busy, 0);
    checkVal("reset_wren", RAMWrEn, 0);
    checkVal("reset_addr", RAMWrAddr, 0);
    checkVal("reset_data", RAMWrData, 0);
    Rst = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    checkVal("idle_no_write", wrAddr.size(), 0);
    checkVal("idle_no_fin", finCnt, 0);

    runGen(2'b01, -1, -1, -1);  // easy
    runGen(2'b11, -1, -1, -1);  // hard
    runGen(2'b10, -1, -1, -1);  // medium
    runGen(2'b00, -1, -1, -1);  // 00 treated as easy
    runGen(2'b01, -1, 8, -1);   // Diff change mid-run ignored
    runGen(2'b01, 10, -1, -1);  // GoGen while busy ignored
    runGen(2'b11, -1, -1, 5);   // reset after 5 writes
    runGen(2'b01, -1, -1, -1);  // restart from address 0

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
